// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Multi-channel reset controller. It synchronises deassertion of the board
// reset, honours a level-sensitive soft reset request, holds every channel in
// reset for HOLD_CYCLES, and then releases N_CH active-low channel resets,
// either all at once (STAGED=0) or one by one in index order, STAGE_CYCLES
// apart (STAGED=1).
//
// Ports
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset; deassertion is synchronised
//   hit_reset    in   soft reset request, level-sensitive, synchronous to clk
//   ch_en        in   [N_CH]  per-channel enable; 0 keeps that channel in reset
//   rst_n_out    out  [N_CH]  registered active-low channel resets
//   seq_done     out  high once the whole release sequence has completed
//   reset_count  out  [8]     saturating count of soft reset requests
//
// Handshake: none. hit_reset is a level, sampled on every rising edge; its
// 0->1 transitions are counted, and while it is high the FSM is held in
// ASSERT.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_CH         = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_CYCLES = 8,
    parameter int STAGED       = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            hit_reset,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] rst_n_out,
    output logic            seq_done,
    output logic [7:0]      reset_count
);

    // Refuse to elaborate with parameters outside their legal range.
    if (N_CH < 1 || HOLD_CYCLES < 1 || STAGE_CYCLES < 1 ||
        (STAGED != 0 && STAGED != 1) || SYNC_STAGES < 2) begin : g_param_check
        $error("reset_sequencer: parameter out of range");
    end

    localparam int MAX_CYC = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Reset deassertion synchroniser: asserted asynchronously, a chain of 1s
    // shifts in after reset_n is removed.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Sequencing FSM
    // -------------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [IDX_W-1:0] idx_q,      idx_d;       // index of the last released channel
    logic [N_CH-1:0]  released_q, released_d;
    logic             seq_done_q, seq_done_d;
    logic [N_CH-1:0]  rst_n_out_q;
    logic             hit_prev_q;
    logic [7:0]       reset_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            released_q <= '0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            released_q <= released_d;
            seq_done_q <= seq_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        released_d = released_q;

        if (hit_reset) begin
            // A soft reset request overrides any release step in the same cycle.
            state_d    = ST_ASSERT;
            cnt_d      = '0;
            idx_d      = '0;
            released_d = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    cnt_d      = '0;
                    idx_d      = '0;
                    released_d = '0;
                    if (sync_rst_n) begin
                        state_d = ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        idx_d = '0;
                        if (STAGED == 0) begin
                            released_d = '1;
                            state_d    = ST_RUN;
                        end else begin
                            released_d[0] = 1'b1;
                            // A single channel has nothing left to stage.
                            state_d = (N_CH == 1) ? ST_RUN : ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d             = '0;
                        idx_d             = idx_q + 1'b1;
                        released_d[idx_d] = 1'b1;
                        if (idx_d == IDX_LAST) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    // Idle: outputs stay as they are until a reset.
                end

                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    // seq_done follows the full released vector through one register so it
    // rises on the same edge as the last channel's output register.
    always_comb begin
        seq_done_d = 1'b0;
        if (!hit_reset) begin
            seq_done_d = &released_q;
        end
    end

    // -------------------------------------------------------------------------
    // Channel output register and soft reset counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_n_out_q <= '0;
        end else begin
            rst_n_out_q <= released_q & ch_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_prev_q    <= 1'b0;
            reset_count_q <= 8'd0;
        end else begin
            hit_prev_q <= hit_reset;
            if (hit_reset && !hit_prev_q && (reset_count_q != 8'hFF)) begin
                reset_count_q <= reset_count_q + 8'd1;
            end
        end
    end

    assign rst_n_out   = rst_n_out_q;
    assign seq_done    = seq_done_q;
    assign reset_count = reset_count_q;

endmodule
